// File: rtl/clock_pkg.sv
// Shared constants, en bit map and adjust-pulse decode for the clock core.
package clock_pkg;

  localparam int HOURS_MAX = 23;
  localparam int MINS_MAX  = 59;
  localparam int SECS_MAX  = 59;

  localparam int HOURS_W = 5;
  localparam int MINS_W  = 6;
  localparam int SECS_W  = 6;
  localparam int EN_W    = 5;

  localparam int EN_RUN  = 0;
  localparam int EN_AMIN = 1;
  localparam int EN_AHR  = 2;
  localparam int EN_TMIN = 3;
  localparam int EN_THR  = 4;

  typedef struct packed {
    logic inc;
    logic dec;
  } step_t;

  // Both buttons in the same cycle cancel to a no-op.
  function automatic step_t adj_step(input logic sel, input logic adjust,
                                     input logic up, input logic down);
    step_t s;
    s.inc = sel & adjust & up & ~down;
    s.dec = sel & adjust & down & ~up;
    return s;
  endfunction

endpackage

// File: rtl/clock_if.sv
// Control/display bundle between the alarm FSM side and the clock core.
interface clock_if;
  import clock_pkg::*;

  logic [EN_W-1:0]    en;
  logic               adjust;
  logic               up;
  logic               down;
  logic [SECS_W-1:0]  secs;
  logic               z;
  logic [HOURS_W-1:0] disp_hh;
  logic [MINS_W-1:0]  disp_mm;
  logic               tick;

  modport master (
    output en, adjust, up, down,
    input  secs, z, disp_hh, disp_mm, tick
  );

  modport slave (
    input  en, adjust, up, down,
    output secs, z, disp_hh, disp_mm, tick
  );

endinterface

// File: rtl/clock_mod_counter.sv
// Modulo-(MAX+1) up/down counter with clear; wrap flags an increment past MAX.
module mod_counter #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MAX);

  logic up_only;
  logic dn_only;

  assign up_only = inc & ~dec & ~clr;
  assign dn_only = dec & ~inc & ~clr;
  assign wrap    = up_only & (value == TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (up_only) begin
      value <= (value == TOP) ? '0 : value + W'(1);
    end else if (dn_only) begin
      value <= (value == '0) ? TOP : value - W'(1);
    end
  end

endmodule

// File: rtl/clock_core.sv
// Time-of-day and alarm registers with 1 Hz prescaler and button adjust.
// Build option CLOCK_SECS_CLEAR_EN: a time-minutes adjust also restarts the second.
module clock_core
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input logic     clk,
  input logic     rst,
  clock_if.slave  bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);

  logic [PW-1:0]      presc;
  logic               tick_q;
  logic               secs_clr;

  step_t              thr_s;
  step_t              tmin_s;
  step_t              ahr_s;
  step_t              amin_s;
  logic               thr_adj;
  logic               tmin_adj;

  logic [SECS_W-1:0]  secs_v;
  logic [MINS_W-1:0]  tmin_v;
  logic [HOURS_W-1:0] thr_v;
  logic [MINS_W-1:0]  amin_v;
  logic [HOURS_W-1:0] ahr_v;

  logic               secs_wrap;
  logic               tmin_wrap;
  logic               thr_wrap;
  logic               ahr_wrap;
  logic               amin_wrap;
  logic               unused_wraps;

  logic               tmin_inc;
  logic               tmin_dec;
  logic               thr_inc;
  logic               thr_dec;

  assign thr_s  = adj_step(bus.en[EN_THR],  bus.adjust, bus.up, bus.down);
  assign tmin_s = adj_step(bus.en[EN_TMIN], bus.adjust, bus.up, bus.down);
  assign ahr_s  = adj_step(bus.en[EN_AHR],  bus.adjust, bus.up, bus.down);
  assign amin_s = adj_step(bus.en[EN_AMIN], bus.adjust, bus.up, bus.down);

  assign thr_adj  = thr_s.inc  | thr_s.dec;
  assign tmin_adj = tmin_s.inc | tmin_s.dec;

`ifdef CLOCK_SECS_CLEAR_EN
  assign secs_clr = tmin_adj;
`else
  assign secs_clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (secs_clr) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.en[EN_RUN]) begin
        if (presc == PRESC_TC) begin
          presc  <= '0;
          tick_q <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  // An adjust on a time field overrides (and swallows) any carry into it;
  // an adjusted minutes field never carries on into hours.
  assign tmin_inc = tmin_adj ? tmin_s.inc : secs_wrap;
  assign tmin_dec = tmin_adj & tmin_s.dec;
  assign thr_inc  = thr_adj ? thr_s.inc : (tmin_wrap & ~tmin_adj);
  assign thr_dec  = thr_adj & thr_s.dec;

  mod_counter #(.MAX(SECS_MAX), .W(SECS_W)) u_secs (
    .clk   (clk),
    .rst   (rst),
    .inc   (tick_q),
    .dec   (1'b0),
    .clr   (secs_clr),
    .value (secs_v),
    .wrap  (secs_wrap)
  );

  mod_counter #(.MAX(MINS_MAX), .W(MINS_W)) u_tmin (
    .clk   (clk),
    .rst   (rst),
    .inc   (tmin_inc),
    .dec   (tmin_dec),
    .clr   (1'b0),
    .value (tmin_v),
    .wrap  (tmin_wrap)
  );

  mod_counter #(.MAX(HOURS_MAX), .W(HOURS_W)) u_thr (
    .clk   (clk),
    .rst   (rst),
    .inc   (thr_inc),
    .dec   (thr_dec),
    .clr   (1'b0),
    .value (thr_v),
    .wrap  (thr_wrap)
  );

  mod_counter #(.MAX(MINS_MAX), .W(MINS_W)) u_amin (
    .clk   (clk),
    .rst   (rst),
    .inc   (amin_s.inc),
    .dec   (amin_s.dec),
    .clr   (1'b0),
    .value (amin_v),
    .wrap  (amin_wrap)
  );

  mod_counter #(.MAX(HOURS_MAX), .W(HOURS_W)) u_ahr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ahr_s.inc),
    .dec   (ahr_s.dec),
    .clr   (1'b0),
    .value (ahr_v),
    .wrap  (ahr_wrap)
  );

  // Hours roll over silently and alarm fields never carry.
  assign unused_wraps = thr_wrap ^ ahr_wrap ^ amin_wrap;

  assign bus.secs    = secs_v;
  assign bus.tick    = tick_q;
  assign bus.z       = (thr_v == ahr_v) && (tmin_v == amin_v);
  assign bus.disp_hh = (bus.en[EN_AHR] | bus.en[EN_AMIN]) ? ahr_v  : thr_v;
  assign bus.disp_mm = (bus.en[EN_AHR] | bus.en[EN_AMIN]) ? amin_v : tmin_v;

endmodule

// File: tb/tb_clock_core.sv
// Directed self-checking bench for clock_core at TICK_DIV=4.
module tb_clock_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   ticks;

`ifdef CLOCK_SECS_CLEAR_EN
  localparam int SECS_AFTER_ADJ = 0;
  localparam int SECS_AFTER_RUN = 0;
`else
  localparam int SECS_AFTER_ADJ = 40;
  localparam int SECS_AFTER_RUN = 41;
`endif

  clock_if bus();

  clock_core #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic u, input logic d);
    bus.up   = u;
    bus.down = d;
    step(1);
    bus.up   = 1'b0;
    bus.down = 1'b0;
  endtask

  task automatic do_reset();
    bus.en     = '0;
    bus.adjust = 1'b0;
    bus.up     = 1'b0;
    bus.down   = 1'b0;
    rst        = 1'b1;
    step(1);
    rst        = 1'b0;
  endtask

  initial begin
    bus.en     = '0;
    bus.adjust = 1'b0;
    bus.up     = 1'b0;
    bus.down   = 1'b0;
    step(1);
    chk("rst_secs", bus.secs, 0);
    chk("rst_z", bus.z, 1);
    chk("rst_hh", bus.disp_hh, 0);
    chk("rst_mm", bus.disp_mm, 0);
    chk("rst_tick", bus.tick, 0);

    // Free run: 240 cycles -> 59 seconds, then minute rollover.
    rst    = 1'b0;
    bus.en = 5'b00001;
    ticks  = 0;
    for (int i = 0; i < 240; i++) begin
      if (i == 3) chk("tick_early", bus.tick, 0);
      if (i == 4) chk("tick_first", bus.tick, 1);
      if (bus.tick) ticks++;
      step(1);
    end
    chk("run_secs59", bus.secs, 59);
    chk("run_ticks59", ticks, 59);
    chk("run_mm0", bus.disp_mm, 0);
    step(4);
    chk("run_secs0", bus.secs, 0);
    chk("run_mm1", bus.disp_mm, 1);
    chk("run_hh0", bus.disp_hh, 0);

    // 23:59:59 rollover to midnight.
    do_reset();
    bus.adjust = 1'b1;
    bus.en = 5'b10000;
    pulse(1'b0, 1'b1);
    chk("preset_hh23", bus.disp_hh, 23);
    bus.en = 5'b01000;
    pulse(1'b0, 1'b1);
    chk("preset_mm59", bus.disp_mm, 59);
    bus.adjust = 1'b0;
    bus.en = 5'b00001;
    step(240);
    chk("eod_secs59", bus.secs, 59);
    chk("eod_hh23", bus.disp_hh, 23);
    chk("eod_mm59", bus.disp_mm, 59);
    step(1);
    chk("midnight_secs", bus.secs, 0);
    chk("midnight_mm", bus.disp_mm, 0);
    chk("midnight_hh", bus.disp_hh, 0);

    // Hours adjust wrap and button rules.
    do_reset();
    bus.adjust = 1'b1;
    bus.en = 5'b10000;
    pulse(1'b0, 1'b1);
    chk("hh_dec_wrap", bus.disp_hh, 23);
    pulse(1'b1, 1'b0);
    chk("hh_inc_wrap", bus.disp_hh, 0);
    pulse(1'b1, 1'b0);
    chk("hh_inc", bus.disp_hh, 1);
    pulse(1'b1, 1'b1);
    chk("hh_both", bus.disp_hh, 1);
    bus.adjust = 1'b0;
    pulse(1'b1, 1'b0);
    chk("hh_no_adjust", bus.disp_hh, 1);

    // Alarm minutes wrap without carry while seconds keep running.
    do_reset();
    bus.adjust = 1'b1;
    bus.en = 5'b00100;
    pulse(1'b1, 1'b0);
    chk("ahh_set1", bus.disp_hh, 1);
    bus.en = 5'b00011;
    pulse(1'b0, 1'b1);
    chk("amm_dec_wrap", bus.disp_mm, 59);
    pulse(1'b1, 1'b0);
    chk("amm_inc_wrap", bus.disp_mm, 0);
    chk("ahh_no_carry", bus.disp_hh, 1);
    step(3);
    chk("alarm_adj_secs", bus.secs, 1);
    bus.adjust = 1'b0;
    bus.en = 5'b00000;
    step(1);
    chk("time_hh_untouched", bus.disp_hh, 0);
    chk("time_mm_untouched", bus.disp_mm, 0);
    chk("z_alarm_diff", bus.z, 0);

    // Alarm match at 07:30.
    do_reset();
    bus.adjust = 1'b1;
    bus.en = 5'b10000;
    repeat (7) pulse(1'b1, 1'b0);
    bus.en = 5'b01000;
    repeat (30) pulse(1'b1, 1'b0);
    chk("z_time_only", bus.z, 0);
    bus.en = 5'b00100;
    repeat (7) pulse(1'b1, 1'b0);
    bus.en = 5'b00010;
    repeat (30) pulse(1'b1, 1'b0);
    chk("alarm_hh7", bus.disp_hh, 7);
    chk("alarm_mm30", bus.disp_mm, 30);
    chk("z_match", bus.z, 1);
    pulse(1'b1, 1'b0);
    chk("z_mismatch", bus.z, 0);
    bus.adjust = 1'b0;
    bus.en = 5'b00000;
    step(1);
    chk("time_hh7", bus.disp_hh, 7);
    chk("time_mm30", bus.disp_mm, 30);

    // Asynchronous reset mid-second, then a full prescaler period.
    do_reset();
    bus.en = 5'b00001;
    step(52);
    chk("pre_rst_secs12", bus.secs, 12);
    chk("pre_rst_tick", bus.tick, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_secs", bus.secs, 0);
    chk("arst_tick", bus.tick, 0);
    chk("arst_z", bus.z, 1);
    chk("arst_hh", bus.disp_hh, 0);
    chk("arst_mm", bus.disp_mm, 0);
    step(1);
    rst = 1'b0;
    step(3);
    chk("post_rst_no_tick", bus.tick, 0);
    step(1);
    chk("post_rst_tick", bus.tick, 1);

    // Time-minutes adjust at secs=40: seconds clear only in the option build.
    do_reset();
    bus.en = 5'b00001;
    step(161);
    chk("secs40", bus.secs, 40);
    bus.adjust = 1'b1;
    bus.en = 5'b01001;
    pulse(1'b1, 1'b0);
    chk("adj_secs", bus.secs, SECS_AFTER_ADJ);
    chk("adj_mm1", bus.disp_mm, 1);
    step(3);
    chk("adj_secs_run", bus.secs, SECS_AFTER_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
